// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size
// encodings and the default data-memory window base.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        STORE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4,
        RESP      = 3'd5
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [31:0] LSU_DEFAULT_BASE = 32'h80020000;

    // Offset of the last byte touched by an access, relative to its first byte.
    function automatic logic [1:0] size_span(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_span = 2'd0;
            SIZE_HALF: size_span = 2'd1;
            default:   size_span = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane handling: extracts/extends the addressed byte or half of a
// memory word for loads and merges sub-word store data into a read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic [1:0]  lane_addr,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_byte [4];
    logic [3:0]  lane_hit;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane 0 is the most significant byte (lowest address, big-endian).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_byte[gi] = word_in[31-8*gi -: 8];
            assign lane_hit[gi]  = (size == SIZE_BYTE) ? (lane_addr == LANE) :
                                   (size == SIZE_HALF) ? (lane_addr[1] == LANE[1]) :
                                   1'b0;
            // The even lane of a half holds its high-order byte.
            assign merge_data[31-8*gi -: 8] =
                !lane_hit[gi]                              ? lane_byte[gi] :
                (size == SIZE_HALF && LANE[0] == 1'b0)     ? wdata[15:8]   :
                                                             wdata[7:0];
        end
    endgenerate

    assign byte_val = lane_byte[lane_addr];
    assign half_val = lane_addr[1] ? word_in[15:0] : word_in[31:16];

    always_comb begin
        load_data = 32'h0;
        case (size)
            SIZE_BYTE: load_data = {{24{signed_ld & byte_val[7]}}, byte_val};
            SIZE_HALF: load_data = {{16{signed_ld & half_val[15]}}, half_val};
            SIZE_WORD: load_data = word_in;
            default:   load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a word-wide big-endian data
// memory; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = LSU_DEFAULT_BASE,
    parameter int          MEM_BYTES = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write,
    output logic        mem_enable
);

    // Window bounds in 33 bits so an access wrapping past 2^32 lands above WIN_HI.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(MEM_BYTES) - 33'd1;

    lsu_state_t  state_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [1:0]  lane_reg;
    logic [15:0] wdata_reg;
    logic        ready_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_error_reg;
    logic        mem_enable_reg;
    logic        mem_rw_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    logic [32:0] first_byte;
    logic [32:0] last_byte;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign first_byte   = {1'b0, req_addr};
    assign last_byte    = first_byte + {31'd0, size_span(req_size)};
    assign misaligned   = ((req_size == SIZE_HALF) && req_addr[0]) ||
                          ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign out_of_range = (first_byte < WIN_LO) || (last_byte > WIN_HI);
    assign req_err      = (req_size == SIZE_ILLEGAL) || misaligned || out_of_range;

    lsu_lane u_lane (
        .word_in    (mem_data_out),
        .size       (size_reg),
        .signed_ld  (signed_reg),
        .lane_addr  (lane_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            size_reg       <= SIZE_BYTE;
            signed_reg     <= 1'b0;
            lane_reg       <= 2'b00;
            wdata_reg      <= 16'h0;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'h0;
            resp_error_reg <= 1'b0;
            mem_enable_reg <= 1'b0;
            mem_rw_reg     <= 1'b1;
            mem_addr_reg   <= 32'h0;
            mem_wdata_reg  <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        size_reg     <= req_size;
                        signed_reg   <= req_signed;
                        lane_reg     <= req_addr[1:0];
                        wdata_reg    <= req_wdata[15:0];
                        mem_addr_reg <= {req_addr[31:2], 2'b00};
                        ready_reg    <= 1'b0;
                        if (req_err) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_error_reg <= 1'b1;
                            resp_rdata_reg <= 32'h0;
                        end else if (!req_write) begin
                            state_reg      <= LOAD;
                            mem_enable_reg <= 1'b1;
                            mem_rw_reg     <= 1'b1;
                        end else if (req_size == SIZE_WORD) begin
                            state_reg      <= STORE;
                            mem_enable_reg <= 1'b1;
                            mem_rw_reg     <= 1'b0;
                            mem_wdata_reg  <= req_wdata;
                        end else begin
                            state_reg      <= RMW_READ;
                            mem_enable_reg <= 1'b1;
                            mem_rw_reg     <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_reg      <= RESP;
                    mem_enable_reg <= 1'b0;
                    resp_valid_reg <= 1'b1;
                    resp_error_reg <= 1'b0;
                    resp_rdata_reg <= load_data;
                end
                STORE: begin
                    state_reg      <= RESP;
                    mem_enable_reg <= 1'b0;
                    mem_rw_reg     <= 1'b1;
                    resp_valid_reg <= 1'b1;
                    resp_error_reg <= 1'b0;
                    resp_rdata_reg <= 32'h0;
                end
                RMW_READ: begin
                    // Enable stays high; the merged word is written next cycle.
                    state_reg     <= RMW_WRITE;
                    mem_rw_reg    <= 1'b0;
                    mem_wdata_reg <= merge_data;
                end
                RMW_WRITE: begin
                    state_reg      <= RESP;
                    mem_enable_reg <= 1'b0;
                    mem_rw_reg     <= 1'b1;
                    resp_valid_reg <= 1'b1;
                    resp_error_reg <= 1'b0;
                    resp_rdata_reg <= 32'h0;
                end
                RESP: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    ready_reg      <= 1'b1;
                end
                default: begin
                    state_reg      <= IDLE;
                    ready_reg      <= 1'b1;
                    resp_valid_reg <= 1'b0;
                    mem_enable_reg <= 1'b0;
                    mem_rw_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = ready_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_rdata     = resp_rdata_reg;
    assign resp_error     = resp_error_reg;
    assign mem_address    = mem_addr_reg;
    assign mem_data_in    = mem_wdata_reg;
    assign mem_read_write = mem_rw_reg;
    assign mem_enable     = mem_enable_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural big-endian word memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;
    logic        mem_enable;

    logic [31:0] mem_model [0:1023];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    load_store_unit #(.BASE_ADDR(32'h80020000), .MEM_BYTES(4096)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write),
        .mem_enable     (mem_enable)
    );

    always @(posedge clock)
        if (mem_enable && !mem_read_write)
            mem_model[mem_address[11:2]] <= mem_data_in;

    assign mem_data_out = (mem_enable && mem_read_write) ? mem_model[mem_address[11:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Latency = posedges from acceptance to the first posedge seeing resp_valid.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic er, output logic en_seen);
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        en_seen    = mem_enable;
        lat        = 99;
        rd         = 32'hxxxxxxxx;
        er         = 1'bx;
        @(posedge clock);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 1) req_valid = 1'b0;
            if (mem_enable) en_seen = 1'b1;
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                er  = resp_error;
                break;
            end
        end
        $display("req wr=%0b size=%0d signed=%0b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
                 wr, sz, sg, addr, wd, lat, rd, er);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        en;
    int          acc, resps, viol;
    logic        pending;

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_error", 32'(resp_error), 32'd0);
        check("rst_mem_en", 32'(mem_enable), 32'd0);
        check("rst_mem_rw", 32'(mem_read_write), 32'd1);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_din", mem_data_in, 32'h0);
        reset = 1'b0;

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h80020010, 32'hDEADBEEF, lat, rd, er, en);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(er), 32'd0);
        check("sw_rdata", rd, 32'h0);
        check("sw_mem", mem_model[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h80020010, 32'h0, lat, rd, er, en);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", rd, 32'hDEADBEEF);

        // Sub-word loads
        do_req(1'b0, 2'b00, 1'b1, 32'h80020011, 32'h0, lat, rd, er, en);
        check("lb_s_rdata", rd, 32'hFFFFFFAD);
        check("lb_s_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b01, 1'b0, 32'h80020012, 32'h0, lat, rd, er, en);
        check("lhu_rdata", rd, 32'h0000BEEF);
        do_req(1'b0, 2'b01, 1'b1, 32'h80020010, 32'h0, lat, rd, er, en);
        check("lh_s_rdata", rd, 32'hFFFFDEAD);

        // Sub-word stores (read-modify-write)
        do_req(1'b1, 2'b00, 1'b0, 32'h80020013, 32'h12345655, lat, rd, er, en);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_mem", mem_model[4], 32'hDEADBE55);
        check("sb_err", 32'(er), 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'h80020012, 32'hFFFF8421, lat, rd, er, en);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_mem", mem_model[4], 32'hDEAD8421);
        do_req(1'b0, 2'b01, 1'b1, 32'h80020012, 32'h0, lat, rd, er, en);
        check("lh_neg_rdata", rd, 32'hFFFF8421);
        do_req(1'b0, 2'b00, 1'b0, 32'h80020012, 32'h0, lat, rd, er, en);
        check("lbu_rdata", rd, 32'h00000084);

        // Last word of the window is legal
        do_req(1'b1, 2'b10, 1'b0, 32'h80020FFC, 32'hCAFEF00D, lat, rd, er, en);
        check("sw_top_err", 32'(er), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h80020FFC, 32'h0, lat, rd, er, en);
        check("lw_top_rdata", rd, 32'hCAFEF00D);

        // Error cases
        do_req(1'b0, 2'b01, 1'b0, 32'h80020011, 32'h0, lat, rd, er, en);
        check("e_half_err", 32'(er), 32'd1);
        check("e_half_rdata", rd, 32'h0);
        check("e_half_en", 32'(en), 32'd0);
        check("e_half_lat", 32'(lat), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h8001FFFC, 32'h0, lat, rd, er, en);
        check("e_low_err", 32'(er), 32'd1);
        check("e_low_en", 32'(en), 32'd0);
        check("e_low_lat", 32'(lat), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h80021000, 32'h0, lat, rd, er, en);
        check("e_high_err", 32'(er), 32'd1);
        check("e_high_rdata", rd, 32'h0);
        check("e_high_en", 32'(en), 32'd0);
        check("e_high_lat", 32'(lat), 32'd1);
        do_req(1'b1, 2'b11, 1'b0, 32'h80020020, 32'h0, lat, rd, er, en);
        check("e_size_err", 32'(er), 32'd1);
        check("e_size_en", 32'(en), 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 32'h80020000, 32'h000000FF, lat, rd, er, en);
        check("after_err_ok", 32'(er), 32'd0);

        // Reset during RMW_READ
        do_req(1'b1, 2'b10, 1'b0, 32'h80020014, 32'h11223344, lat, rd, er, en);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h80020015;
        req_wdata = 32'h000000AA;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("rmw_rd_en", 32'(mem_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_ready", 32'(req_ready), 32'd1);
        check("ar_resp_valid", 32'(resp_valid), 32'd0);
        check("ar_mem_en", 32'(mem_enable), 32'd0);
        check("ar_mem_rw", 32'(mem_read_write), 32'd1);
        check("ar_mem_addr", mem_address, 32'h0);
        check("ar_mem_din", mem_data_in, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        resps = 0;
        repeat (4) begin
            @(negedge clock);
            if (resp_valid) resps++;
        end
        check("ar_no_resp", 32'(resps), 32'd0);
        check("ar_mem_keep", mem_model[5], 32'h11223344);
        do_req(1'b0, 2'b10, 1'b0, 32'h80020014, 32'h0, lat, rd, er, en);
        check("ar_next_rdata", rd, 32'h11223344);
        check("ar_next_lat", 32'(lat), 32'd2);

        // req_valid held high: one acceptance per response, no ready in flight
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h80020010;
        acc = 0; resps = 0; viol = 0; pending = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (pending && req_ready) viol++;
            if (resp_valid && !pending) viol++;
            if (resp_valid) begin
                resps++;
                pending = 1'b0;
            end
            if (req_ready && req_valid) begin
                acc++;
                pending = 1'b1;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        $display("streaming: acceptances=%0d responses=%0d violations=%0d", acc, resps, viol);
        check("stream_acc", 32'(acc), 32'd4);
        check("stream_resp", 32'(resps), 32'd4);
        check("stream_viol", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
